// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant and optional hold timeout.
// The most recent owner always has the lowest priority in the next search.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST  = TIMEOUT_EN ? 8'(MAX_HOLD - 1) : 8'hFF;

    state_t     state_reg, state_next;
    logic [2:0] gnt_idx_reg, gnt_idx_next;
    logic [2:0] last_idx_reg, last_idx_next;
    logic [7:0] hold_cnt_reg, hold_cnt_next;
    logic       timeout_reg, timeout_next;
    logic [7:0] gnt_reg, gnt_next;
    logic       gnt_valid_reg, gnt_valid_next;

    logic [2:0] search_base;
    logic [7:0] req_rot;
    logic [2:0] win_off;
    logic [2:0] win_idx;
    logic       any_req;
    logic       owner_req;
    logic       hold_expired;

    // Rotate req so bit 0 is the first candidate after the last owner.
    assign search_base = last_idx_reg + 3'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign req_rot[gi] = req[search_base + 3'(gi)];
        end
    endgenerate

    always_comb begin
        win_off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = 3'(k);
            end
        end
    end

    assign win_idx      = search_base + win_off;
    assign any_req      = |req;
    assign owner_req    = req[gnt_idx_reg];
    assign hold_expired = TIMEOUT_EN && (hold_cnt_reg == HOLD_LAST);

    always_comb begin
        state_next    = state_reg;
        gnt_idx_next  = gnt_idx_reg;
        last_idx_next = last_idx_reg;
        hold_cnt_next = hold_cnt_reg;
        timeout_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next    = GRANT;
                    gnt_idx_next  = win_idx;
                    last_idx_next = win_idx;
                    hold_cnt_next = 8'd0;
                end
            end
            GRANT: begin
                if (!owner_req || hold_expired) begin
                    // A forced release only counts when the owner still wants the resource.
                    timeout_next  = owner_req;
                    hold_cnt_next = 8'd0;
                    if (any_req) begin
                        gnt_idx_next  = win_idx;
                        last_idx_next = win_idx;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (hold_cnt_reg != 8'hFF) begin
                    hold_cnt_next = hold_cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign gnt_valid_next = (state_next == GRANT);

    generate
        for (gi = 0; gi < 8; gi++) begin : g_dec
            assign gnt_next[gi] = gnt_valid_next && (gnt_idx_next == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            gnt_idx_reg   <= 3'd0;
            last_idx_reg  <= 3'd7;
            hold_cnt_reg  <= 8'd0;
            timeout_reg   <= 1'b0;
            gnt_reg       <= 8'h00;
            gnt_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            gnt_idx_reg   <= gnt_idx_next;
            last_idx_reg  <= last_idx_next;
            hold_cnt_reg  <= hold_cnt_next;
            timeout_reg   <= timeout_next;
            gnt_reg       <= gnt_next;
            gnt_valid_reg <= gnt_valid_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_idx   = gnt_idx_reg;
    assign gnt_valid = gnt_valid_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic against an owner/queue-level model.
module tb_rr_arbiter8;

    localparam int MAXH = 4;
    localparam logic [7:0] T4_GNT [9] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h20,
                                          8'h20, 8'h20, 8'h20, 8'h08};
    localparam bit         T4_TO  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                          1'b0, 1'b0, 1'b0, 1'b1};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req   = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Model: current owner (-1 = none), cycles held so far, most recent owner, timeout pulse.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 7;
    bit m_to    = 1'b0;

    rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int after);
        for (int k = 1; k <= 8; k++) begin
            if (r[(after + k) % 8]) return (after + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_gnt();
        if (m_owner < 0) return 8'h00;
        return 8'h01 << m_owner;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 7;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r);
        bit rel;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (r != 8'h00) begin
                m_owner = pick(r, m_last);
                m_last  = m_owner;
                m_held  = 1;
            end
        end else begin
            rel = !r[m_owner] || (MAXH != 0 && m_held == MAXH);
            if (rel) begin
                m_to = r[m_owner];
                if (r != 8'h00) begin
                    m_owner = pick(r, m_owner);
                    m_last  = m_owner;
                    m_held  = 1;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_held++;
            end
        end
    endtask

    // Inputs change 1 time unit after the rising edge; the model advances on the same edge.
    task automatic cycle(input logic [7:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_gnt", gnt, 8'h00);
        check("rst_async_valid", gnt_valid, 1'b0);
        check("rst_async_idx", gnt_idx, 3'd0);
        check("rst_async_timeout", timeout, 1'b0);
        cycle(8'hFF);
        check("rst_hold_gnt", gnt, 8'h00);
        check("rst_hold_valid", gnt_valid, 1'b0);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        check("gnt", gnt, exp_gnt());
        check("gnt_valid", gnt_valid, m_owner >= 0);
        check("timeout", timeout, m_to);
        if (gnt_valid) check("gnt_idx", gnt_idx, m_owner[2:0]);
        check("onehot_invariant", gnt, gnt_valid ? (32'd1 << gnt_idx) : 32'd0);
    end

    initial begin
        logic [7:0] r;
        int order[9];

        do_reset();

        // Single requester
        cycle(8'h04);
        check("single_gnt", gnt, 8'h04);
        check("single_idx", gnt_idx, 3'd2);
        cycle(8'h00);
        check("single_rel_gnt", gnt, 8'h00);
        check("single_rel_valid", gnt_valid, 1'b0);

        // Fairness: each owner drops its request right after being granted
        do_reset();
        for (int i = 0; i < 9; i++) begin
            r = 8'hFF;
            if (i != 0) r[m_owner] = 1'b0;
            cycle(r);
            order[i] = m_owner;
            check("fair_model_order", order[i], i % 8);
            check("fair_dut_idx", gnt_idx, i % 8);
        end

        // Reset while a grant is active
        check("pre_reset_valid", gnt_valid, 1'b1);
        do_reset();

        // Timeout rotation between two persistent requesters
        for (int i = 0; i < 9; i++) begin
            cycle(8'h28);
            check("to_gnt", gnt, T4_GNT[i]);
            check("to_pulse", timeout, T4_TO[i]);
        end

        // Sole requester times out and is re-granted
        do_reset();
        for (int i = 0; i < 5; i++) cycle(8'h01);
        check("regrant_gnt", gnt, 8'h01);
        check("regrant_timeout", timeout, 1'b1);
        check("regrant_valid", gnt_valid, 1'b1);

        // Wrap 6 -> 7 -> 0
        do_reset();
        cycle(8'h40);
        check("wrap_first", gnt, 8'h40);
        cycle(8'h81);
        check("wrap_gnt7", gnt, 8'h80);
        check("wrap_idx7", gnt_idx, 3'd7);
        cycle(8'h01);
        check("wrap_gnt0", gnt, 8'h01);

        // Back-to-back handover 1 -> 4
        do_reset();
        cycle(8'h02);
        check("b2b_first", gnt, 8'h02);
        cycle(8'h12);
        check("b2b_hold", gnt, 8'h02);
        cycle(8'h10);
        check("b2b_next", gnt, 8'h10);
        check("b2b_valid", gnt_valid, 1'b1);

        // Owner drops exactly on the timeout edge: voluntary release
        do_reset();
        for (int i = 0; i < 4; i++) cycle(8'h03);
        check("tie_pre", gnt, 8'h01);
        cycle(8'h02);
        check("tie_gnt", gnt, 8'h02);
        check("tie_timeout", timeout, 1'b0);

        // Random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                r = req;
                if ($urandom_range(0, 3) == 0) r = 8'($urandom) & 8'($urandom);
                if ($urandom_range(0, 5) == 0 && m_owner >= 0) r[m_owner] = 1'b0;
                cycle(r);
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
